// File: rtl/uart_rx_fifo_if.sv
// Peripheral bus bundle shared between the CPU-side master and the UART receive block.
// valid/ready handshake with a single register-select address bit.
interface uart_rx_fifo_if;
  logic        valid;
  logic        wr;
  logic        reg_sel;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ready;

  modport master (output valid, wr, reg_sel, din, input dout, ready);
  modport slave  (input valid, wr, reg_sel, din, output dout, ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a small byte FIFO, read through DATA/STATUS registers.
// Raises a level interrupt while received bytes are waiting.
module uart_rx_fifo #(
  parameter int CLK_HZ = 20000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_fifo_if.slave     bus,
  input  logic              rxd,
  output logic              irq
);

  localparam int          DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [15:0] DIV_FULL = 16'(DIV - 1);
  localparam logic [15:0] DIV_HALF = 16'(DIV / 2 - 1);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic              rx_meta, rx_s;
  logic [1:0]        state;
  logic [15:0]       cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              expired;
  logic              rx_push, rx_bad;

  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              nonempty, full;
  logic              acc, do_pop, push_ok, ovr_set;
  logic              clr_ovr, clr_ferr;
  logic              ovr, ferr;
  logic              unused_din;

  // Both synchronizer flops reset to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a real two-stage pipe.
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  assign expired = (cnt == 16'd0);
  assign rx_push = (state == S_STOP) && expired && rx_s;
  assign rx_bad  = (state == S_STOP) && expired && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= DIV_HALF;
            state <= S_START;
          end
        end
        S_START: begin
          if (!expired) begin
            cnt <= cnt - 16'd1;
          end else if (rx_s) begin
            state <= S_IDLE;
          end else begin
            cnt     <= DIV_FULL;
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (!expired) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= DIV_FULL;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        default: begin
          // Leaving STOP straight to IDLE lets a start bit right after the stop centre be caught.
          if (!expired) cnt <= cnt - 16'd1;
          else          state <= S_IDLE;
        end
      endcase
    end
  end

  assign nonempty = (count != '0);
  assign full     = (count == FULL_CNT);
  assign acc      = bus.valid && !bus.ready;
  assign do_pop   = acc && !bus.wr && !bus.reg_sel && nonempty;
  assign push_ok  = rx_push && (!full || do_pop);
  assign ovr_set  = rx_push && full && !do_pop;
  assign clr_ovr  = acc && bus.wr && bus.reg_sel && bus.din[8];
  assign clr_ferr = acc && bus.wr && bus.reg_sel && bus.din[9];
  assign unused_din = ^{bus.din[31:10], bus.din[7:0]};

  // NOTE: storage array has no reset; validity is tracked by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A flag raised in the same cycle as its clear wins.
      ovr  <= ovr_set | (ovr  & ~clr_ovr);
      ferr <= rx_bad  | (ferr & ~clr_ferr);
      irq  <= nonempty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.dout  <= 32'd0;
    end else begin
      bus.ready <= bus.valid & ~bus.ready;
      if (acc && !bus.wr) begin
        if (bus.reg_sel)   bus.dout <= {22'd0, ferr, ovr, 8'(count)};
        else if (nonempty) bus.dout <= {23'd0, 1'b1, mem[rptr]};
        else               bus.dout <= 32'd0;
      end
    end
  end

endmodule
